scope_frame_receiver: RTL and testbench
=======================================

# scope_frame_receiver

Host-side counterpart of the oscilloscope capture core: it arms an acquisition by sending one command byte over the UART byte interface, then receives the 512-byte sample dump and stores it in an internal frame buffer. Readout is a synchronous read port. The block sits between the host-side UART (async_transmitter / async_receiver instances, byte level) and the display or analysis logic. In each completed frame the trigger sample sits at index 256.

## Interface
Parameters:
- FRAME_LEN, 512: bytes per frame; must be a power of two.
- ADDR_W, 9: log2(FRAME_LEN).
- TIMEOUT_CYCLES, 1_000_000: maximum clk cycles allowed between arm and the first byte, and between consecutive bytes.
- TO_W, 20: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  single-cycle request to start one capture.
- slope  in  1  trigger slope sent in command bit 0: 1 = rising, 0 = falling.
- txd_start  out  1  one-cycle strobe to the UART transmitter.
- txd_data  out  8  command byte = {7'b0, slope_latched}.
- txd_busy  in  1  transmitter busy.
- rxd_data_ready  in  1  one-cycle strobe; rxd_data is valid in that cycle.
- rxd_data  in  8  received byte.
- busy  out  1  high from arm accept until DONE or timeout.
- frame_valid  out  1  buffer holds a complete frame.
- frame_done  out  1  one-cycle pulse when the last byte is written.
- timeout_err  out  1  sticky flag; cleared by the next accepted arm or by rst.
- byte_count  out  ADDR_W+1  number of bytes received in the current frame.
- rd_addr  in  ADDR_W  buffer read address.
- rd_data  out  8  buffer read data.

## Operation
- FSM states: IDLE, SEND_CMD, RECV, DONE.
- IDLE: arm=1 → latch slope, clear byte_count, clear timeout_err, clear frame_valid, set busy, go to SEND_CMD. arm is ignored in every other state.
- SEND_CMD: in the first cycle with txd_busy=0, assert txd_start for exactly one cycle with txd_data valid in that cycle, clear the timeout counter, go to RECV.
- RECV: on rxd_data_ready, write rxd_data to mem[byte_count[ADDR_W-1:0]] and increment byte_count.
  - If this write is byte FRAME_LEN-1, go to DONE.
  - The timeout counter clears on every received byte and increments otherwise. When it reaches TIMEOUT_CYCLES: set timeout_err, clear busy, go to IDLE, leave frame_valid=0.
- DONE: lasts one cycle. Pulse frame_done, set frame_valid, clear busy, go to IDLE.
- Bytes arriving in IDLE, SEND_CMD or DONE are discarded. They are not written to the buffer and not counted.
- byte_count saturates at FRAME_LEN. The write address wraps naturally through ADDR_W bits.
- Reset:
  - state = IDLE; busy, frame_valid, frame_done, txd_start, timeout_err = 0; byte_count = 0; txd_data = 0.
  - Buffer contents are not reset.
  - rst asserted mid-frame abandons the frame; frame_valid stays 0.

## Timing
- arm accepted in cycle N with txd_busy=0: busy=1 at N+1, txd_start=1 at N+1, state RECV at N+2.
- If txd_busy=1, txd_start is held off until the first cycle with txd_busy=0.
- Last-byte rxd_data_ready in cycle M: frame_done=1 and frame_valid=1 at M+1, busy=0 at M+1.
- Read port is registered: rd_data reflects mem[rd_addr] one cycle after rd_addr is presented.
- Simultaneous write and read of the same address returns the old data.
- Timeout fires after exactly TIMEOUT_CYCLES cycles without a byte. timeout_err=1 in the cycle after the counter hits the limit.

## Structure
- Shared package holds: FSM state enum, CMD_SLOPE_BIT = 0, TRIG_INDEX = 256, FRAME_LEN default.
- One natural sub-module: frame_ram (simple dual-port, single clock, 8 bits x FRAME_LEN, registered read). Synthesises to block RAM.
- The UART instances stay outside the block.

## Test plan
- Arm with slope=1, txd_busy=0 → one txd_start pulse carrying txd_data=8'h01; rxd model sends bytes 0..255,0..255 → frame_done after byte 512, frame_valid=1, byte_count=512; reads give rd_addr 0 → 8'h00, 300 → 8'h2C, 511 → 8'hFF.
- txd_busy held high for 20 cycles after arm with slope=0 → txd_start held off and then pulses in the first cycle txd_busy=0, with txd_data=8'h00; exactly one pulse.
- TIMEOUT_CYCLES=100; send 10 bytes then stop → timeout_err=1 exactly 100 cycles after the 10th byte, busy=0, frame_valid=0; the next arm clears timeout_err.
- Second arm pulse during RECV, plus stray bytes sent before arm → both ignored; byte_count unaffected, only one command byte transmitted.
- rst asserted after 300 bytes → all outputs return to reset values next cycle; a new arm starts a fresh frame with byte_count starting at 0.

Source files
------------

// File: rtl/scope_frame_receiver_pkg.sv
// Shared definitions for the scope frame receiver: FSM encoding and frame layout constants.
package scope_frame_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND_CMD,
        RECV,
        DONE
    } state_t;

    localparam int unsigned CMD_SLOPE_BIT     = 0;
    localparam int unsigned TRIG_INDEX        = 256;
    localparam int unsigned FRAME_LEN_DEFAULT = 512;

endpackage

// File: rtl/scope_frame_receiver_frame_ram.sv
// Simple dual-port frame buffer, single clock, registered read; a read of the
// address being written in the same cycle returns the old contents.
module scope_frame_receiver_frame_ram #(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/scope_frame_receiver.sv
// Host-side capture receiver: sends the arm/slope command byte, collects one
// FRAME_LEN-byte sample dump into the frame buffer, and flags inter-byte timeouts.
module scope_frame_receiver
    import scope_frame_receiver_pkg::*;
#(
    parameter int unsigned FRAME_LEN      = FRAME_LEN_DEFAULT,
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned TO_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              slope,
    output logic              txd_start,
    output logic [7:0]        txd_data,
    input  logic              txd_busy,
    input  logic              rxd_data_ready,
    input  logic [7:0]        rxd_data,
    output logic              busy,
    output logic              frame_valid,
    output logic              frame_done,
    output logic              timeout_err,
    output logic [ADDR_W:0]   byte_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            wr_en;

    assign wr_en = (state == RECV) && rxd_data_ready;

    // Decoded from state so the strobe lands in the very cycle txd_busy drops.
    assign txd_start = (state == SEND_CMD) && !txd_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            byte_count  <= '0;
            txd_data    <= '0;
            to_cnt      <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        txd_data                <= '0;
                        txd_data[CMD_SLOPE_BIT] <= slope;
                        byte_count              <= '0;
                        timeout_err             <= 1'b0;
                        frame_valid             <= 1'b0;
                        busy                    <= 1'b1;
                        state                   <= SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    if (!txd_busy) begin
                        to_cnt <= '0;
                        state  <= RECV;
                    end
                end
                RECV: begin
                    if (rxd_data_ready) begin
                        to_cnt <= '0;
                        if (byte_count != FULL_CNT) begin
                            byte_count <= byte_count + 1'b1;
                        end
                        // DONE's outputs are loaded on entry so they are visible during DONE.
                        if (byte_count == LAST_IDX) begin
                            frame_done  <= 1'b1;
                            frame_valid <= 1'b1;
                            busy        <= 1'b0;
                            state       <= DONE;
                        end
                    end else if (to_cnt == TO_LIMIT) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    scope_frame_receiver_frame_ram #(
        .DEPTH (FRAME_LEN),
        .ADDR_W(ADDR_W)
    ) u_frame_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(byte_count[ADDR_W-1:0]),
        .wdata(rxd_data),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

endmodule

// File: tb/tb_scope_frame_receiver.sv
// Directed bench for scope_frame_receiver: full frame, command hold-off, timeouts,
// ignored stimulus and mid-frame reset, each with hand-computed expectations.
module tb_scope_frame_receiver;
    import scope_frame_receiver_pkg::*;

    localparam int unsigned FRAME_LEN = 512;
    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned TIMEOUT   = 100;
    localparam int unsigned TO_W      = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              arm = 1'b0;
    logic              slope = 1'b0;
    logic              txd_start;
    logic [7:0]        txd_data;
    logic              txd_busy = 1'b0;
    logic              rxd_data_ready = 1'b0;
    logic [7:0]        rxd_data = '0;
    logic              busy;
    logic              frame_valid;
    logic              frame_done;
    logic              timeout_err;
    logic [ADDR_W:0]   byte_count;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [7:0]        rd_data;

    int checks = 0;
    int errors = 0;

    scope_frame_receiver #(
        .FRAME_LEN     (FRAME_LEN),
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT),
        .TO_W          (TO_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .slope         (slope),
        .txd_start     (txd_start),
        .txd_data      (txd_data),
        .txd_busy      (txd_busy),
        .rxd_data_ready(rxd_data_ready),
        .rxd_data      (rxd_data),
        .busy          (busy),
        .frame_valid   (frame_valid),
        .frame_done    (frame_done),
        .timeout_err   (timeout_err),
        .byte_count    (byte_count),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxd_data       = b;
        rxd_data_ready = 1'b1;
        tick();
        rxd_data_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (txd_start !== 1'b0) begin errors++; $display("FAIL reset_txd_start: got %b expected 0", txd_start); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        checks++; if (byte_count !== 10'd0) begin errors++; $display("FAIL reset_byte_count: got %0d expected 0", byte_count); end
        checks++; if (txd_data !== 8'h00) begin errors++; $display("FAIL reset_txd_data: got %h expected 00", txd_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        txd_busy = 1'b0;
        arm   = 1'b1;
        slope = 1'b1;
        tick();
        arm   = 1'b0;
        slope = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ff_busy_after_arm: got %b expected 1", busy); end
        checks++; if (txd_start !== 1'b1) begin errors++; $display("FAIL ff_txd_start: got %b expected 1", txd_start); end
        checks++; if (txd_data !== 8'h01) begin errors++; $display("FAIL ff_txd_data: got %h expected 01", txd_data); end
        tick();
        checks++; if (txd_start !== 1'b0) begin errors++; $display("FAIL ff_txd_start_single: got %b expected 0", txd_start); end
        for (int i = 0; i < 511; i++) begin
            send_byte(8'(i));
        end
        checks++; if (byte_count !== 10'd511) begin errors++; $display("FAIL ff_count_511: got %0d expected 511", byte_count); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL ff_done_early: got %b expected 0", frame_done); end
        send_byte(8'hFF);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL ff_frame_done: got %b expected 1", frame_done); end
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ff_frame_valid: got %b expected 1", frame_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ff_busy_done: got %b expected 0", busy); end
        checks++; if (byte_count !== 10'd512) begin errors++; $display("FAIL ff_count_512: got %0d expected 512", byte_count); end
        // stray byte during the DONE cycle
        send_byte(8'h77);
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL ff_done_pulse_len: got %b expected 0", frame_done); end
        checks++; if (byte_count !== 10'd512) begin errors++; $display("FAIL ff_count_after_done: got %0d expected 512", byte_count); end
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ff_valid_hold: got %b expected 1", frame_valid); end
        rd_addr = 9'd0;
        tick();
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL ff_rd_0: got %h expected 00", rd_data); end
        rd_addr = 9'd300;
        tick();
        checks++; if (rd_data !== 8'h2C) begin errors++; $display("FAIL ff_rd_300: got %h expected 2c", rd_data); end
        rd_addr = 9'd511;
        tick();
        checks++; if (rd_data !== 8'hFF) begin errors++; $display("FAIL ff_rd_511: got %h expected ff", rd_data); end
    endtask

    task automatic test_busy_holdoff();
        int pulses = 0;
        int j = 0;
        txd_busy = 1'b1;
        arm   = 1'b1;
        slope = 1'b0;
        tick();
        arm = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ho_busy: got %b expected 1", busy); end
        checks++; if (txd_data !== 8'h00) begin errors++; $display("FAIL ho_txd_data: got %h expected 00", txd_data); end
        for (int k = 0; k < 19; k++) begin
            if (txd_start) pulses++;
            tick();
        end
        if (txd_start) pulses++;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL ho_held_off: got %0d pulses expected 0", pulses); end
        txd_busy = 1'b0;
        #1;
        checks++; if (txd_start !== 1'b1) begin errors++; $display("FAIL ho_first_free_cycle: got %b expected 1", txd_start); end
        if (txd_start) pulses++;
        tick();
        // no bytes follow, so the command-to-first-byte timeout must fire
        while (j < 200 && !timeout_err) begin
            if (txd_start) pulses++;
            tick();
            j++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL ho_single_pulse: got %0d pulses expected 1", pulses); end
        checks++; if (j !== 100) begin errors++; $display("FAIL ho_first_byte_timeout: got %0d cycles expected 100", j); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ho_busy_after_timeout: got %b expected 0", busy); end
    endtask

    task automatic test_timeout();
        int j = 0;
        arm   = 1'b1;
        slope = 1'b1;
        tick();
        arm = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_arm_clears: got %b expected 0", timeout_err); end
        tick();
        for (int i = 0; i < 10; i++) begin
            send_byte(8'hA0 + 8'(i));
            if (i < 9) tick();
        end
        while (j < 150 && !timeout_err) begin
            tick();
            j++;
        end
        checks++; if (j !== 100) begin errors++; $display("FAIL to_cycles: got %0d cycles expected 100", j); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", timeout_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b expected 0", busy); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL to_frame_valid: got %b expected 0", frame_valid); end
        checks++; if (byte_count !== 10'd10) begin errors++; $display("FAIL to_count: got %0d expected 10", byte_count); end
        rd_addr = 9'd9;
        tick();
        checks++; if (rd_data !== 8'hA9) begin errors++; $display("FAIL to_rd_9: got %h expected a9", rd_data); end
    endtask

    task automatic test_ignore();
        int pulses = 0;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hEE);
        end
        checks++; if (byte_count !== 10'd10) begin errors++; $display("FAIL ig_stray_count: got %0d expected 10", byte_count); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL ig_sticky: got %b expected 1", timeout_err); end
        arm   = 1'b1;
        slope = 1'b1;
        tick();
        arm   = 1'b0;
        slope = 1'b0;
        if (txd_start) pulses++;
        checks++; if (byte_count !== 10'd0) begin errors++; $display("FAIL ig_count_cleared: got %0d expected 0", byte_count); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL ig_arm_clears: got %b expected 0", timeout_err); end
        tick();
        if (txd_start) pulses++;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(i));
            if (txd_start) pulses++;
        end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        if (txd_start) pulses++;
        checks++; if (byte_count !== 10'd5) begin errors++; $display("FAIL ig_rearm_count: got %0d expected 5", byte_count); end
        checks++; if (txd_data !== 8'h01) begin errors++; $display("FAIL ig_rearm_slope: got %h expected 01", txd_data); end
        send_byte(8'h05);
        if (txd_start) pulses++;
        send_byte(8'h06);
        if (txd_start) pulses++;
        checks++; if (byte_count !== 10'd7) begin errors++; $display("FAIL ig_count_7: got %0d expected 7", byte_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ig_busy: got %b expected 1", busy); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL ig_cmd_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_reset_midframe();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        arm   = 1'b1;
        slope = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h55);
        end
        checks++; if (byte_count !== 10'd300) begin errors++; $display("FAIL rm_count_300: got %0d expected 300", byte_count); end
        rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rm_frame_valid: got %b expected 0", frame_valid); end
        checks++; if (byte_count !== 10'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", byte_count); end
        checks++; if (txd_data !== 8'h00) begin errors++; $display("FAIL rm_txd_data: got %h expected 00", txd_data); end
        checks++; if (txd_start !== 1'b0) begin errors++; $display("FAIL rm_txd_start: got %b expected 0", txd_start); end
        rst = 1'b0;
        tick();
        arm   = 1'b1;
        slope = 1'b0;
        tick();
        arm = 1'b0;
        checks++; if (byte_count !== 10'd0) begin errors++; $display("FAIL rm_fresh_count: got %0d expected 0", byte_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_fresh_busy: got %b expected 1", busy); end
        tick();
        rd_addr = 9'd0;
        send_byte(8'hFF);
        checks++; if (rd_data !== 8'h55) begin errors++; $display("FAIL rm_read_old: got %h expected 55", rd_data); end
        checks++; if (byte_count !== 10'd1) begin errors++; $display("FAIL rm_count_1: got %0d expected 1", byte_count); end
        tick();
        checks++; if (rd_data !== 8'hFF) begin errors++; $display("FAIL rm_read_new: got %h expected ff", rd_data); end
        for (int i = 1; i < 512; i++) begin
            send_byte(8'(255 - i));
        end
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL rm_frame_valid_end: got %b expected 1", frame_valid); end
        checks++; if (byte_count !== 10'd512) begin errors++; $display("FAIL rm_count_512: got %0d expected 512", byte_count); end
        rd_addr = 9'(TRIG_INDEX);
        tick();
        checks++; if (rd_data !== 8'hFF) begin errors++; $display("FAIL rm_rd_trig: got %h expected ff", rd_data); end
        rd_addr = 9'd300;
        tick();
        checks++; if (rd_data !== 8'hD3) begin errors++; $display("FAIL rm_rd_300: got %h expected d3", rd_data); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_frame();
        test_busy_holdoff();
        test_timeout();
        test_ignore();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
